mainm_cache: RTL and testbench



---
 rtl/mainm_cache_pkg.sv | 20 ++
 rtl/mainm_cache_ram.sv | 23 ++
 rtl/mainm_cache.sv | 194 +++++++++++++++++++
 tb/tb_mainm_cache.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mainm_cache_pkg.sv
// rtl/mainm_cache_pkg.sv - shared state encoding and default geometry for mainm_cache
package mainm_cache_pkg;

  localparam int DEF_IDX_W  = 8;
  localparam int DEF_ADDR_W = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_FILL,
    S_WRITE,
    S_DONE
  } state_t;

  // Tag bits left after removing the line index and the byte offset
  function automatic int tag_width(input int addr_w, input int idx_w);
    return addr_w - idx_w - 2;
  endfunction

endpackage

// File: rtl/mainm_cache_ram.sv
// rtl/mainm_cache_ram.sv - synchronous-read tag+data RAM with one shared read/write port
module mainm_cache_ram #(
  parameter int AW = 8,
  parameter int DW = 54
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  // Read-first block RAM: the read returns the old contents on a write cycle
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/mainm_cache.sv
// rtl/mainm_cache.sv - direct-mapped write-through cache on the main-memory port (optional MAINM_CACHE_STATS_EN)
module mainm_cache
  import mainm_cache_pkg::*;
#(
  parameter int IDX_W  = DEF_IDX_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] a,
  input  logic [31:0]       d,
  input  logic              we,
  input  logic              rd,
  output logic [31:0]       spo,
  output logic              ready,
  output logic [ADDR_W-1:0] a_mem,
  output logic [31:0]       d_mem,
  output logic              we_mem,
  output logic              rd_mem,
  input  logic [31:0]       spo_mem,
  input  logic              ready_mem
`ifdef MAINM_CACHE_STATS_EN
  ,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
`endif
);

  localparam int TAG_W = tag_width(ADDR_W, IDX_W);
  localparam int RAM_W = 32 + TAG_W;
  localparam int LINES = 1 << IDX_W;

  state_t              state, state_n;
  logic [ADDR_W-1:0]   cap_a, cap_a_n;
  logic [31:0]         cap_d, cap_d_n;
  logic                wr_first, wr_first_n;
  logic [LINES-1:0]    valid;
  logic                set_valid;

  logic [31:0]         spo_n, d_mem_n;
  logic [ADDR_W-1:0]   a_mem_n;
  logic                ready_n, we_mem_n, rd_mem_n;

  logic                ram_we;
  logic [IDX_W-1:0]    ram_addr;
  logic [RAM_W-1:0]    ram_wdata, ram_rdata;

  logic [IDX_W-1:0]    cap_idx, in_idx;
  logic [TAG_W-1:0]    cap_tag;
  logic                hit;
  logic                unused_a_low;

  assign cap_idx      = cap_a[IDX_W+1:2];
  assign cap_tag      = cap_a[ADDR_W-1:IDX_W+2];
  assign in_idx       = a[IDX_W+1:2];
  assign hit          = valid[cap_idx] && (ram_rdata[RAM_W-1:32] == cap_tag);
  assign unused_a_low = ^a[1:0];

  mainm_cache_ram #(
    .AW (IDX_W),
    .DW (RAM_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Next-state, next-output and array-port decode for the request FSM
  always_comb begin
    state_n    = state;
    cap_a_n    = cap_a;
    cap_d_n    = cap_d;
    wr_first_n = 1'b0;
    spo_n      = spo;
    ready_n    = 1'b0;
    a_mem_n    = a_mem;
    d_mem_n    = d_mem;
    we_mem_n   = we_mem;
    rd_mem_n   = rd_mem;
    set_valid  = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = cap_idx;
    ram_wdata  = {cap_tag, cap_d};

    case (state)
      S_IDLE: begin
        // The array is addressed straight from the request so LOOKUP sees its output
        ram_addr = in_idx;
        if (we) begin
          cap_a_n    = {a[ADDR_W-1:2], 2'b00};
          cap_d_n    = d;
          wr_first_n = 1'b1;
          we_mem_n   = 1'b1;
          a_mem_n    = {a[ADDR_W-1:2], 2'b00};
          d_mem_n    = d;
          state_n    = S_WRITE;
        end else if (rd) begin
          cap_a_n = {a[ADDR_W-1:2], 2'b00};
          state_n = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (hit) begin
          spo_n   = ram_rdata[31:0];
          ready_n = 1'b1;
          state_n = S_DONE;
        end else begin
          rd_mem_n = 1'b1;
          a_mem_n  = cap_a;
          state_n  = S_FILL;
        end
      end
      S_FILL: begin
        if (ready_mem) begin
          ram_we    = ~rst;
          ram_wdata = {cap_tag, spo_mem};
          set_valid = 1'b1;
          rd_mem_n  = 1'b0;
          spo_n     = spo_mem;
          ready_n   = 1'b1;
          state_n   = S_DONE;
        end
      end
      S_WRITE: begin
        // Allocate on the first WRITE cycle; completion still waits for memory
        if (wr_first) begin
          ram_we    = ~rst;
          set_valid = 1'b1;
        end
        if (ready_mem) begin
          we_mem_n = 1'b0;
          ready_n  = 1'b1;
          state_n  = S_DONE;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // State, capture, output and valid registers; reset drops everything in one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cap_a    <= '0;
      cap_d    <= '0;
      wr_first <= 1'b0;
      spo      <= '0;
      ready    <= 1'b0;
      a_mem    <= '0;
      d_mem    <= '0;
      we_mem   <= 1'b0;
      rd_mem   <= 1'b0;
      valid    <= '0;
    end else begin
      state    <= state_n;
      cap_a    <= cap_a_n;
      cap_d    <= cap_d_n;
      wr_first <= wr_first_n;
      spo      <= spo_n;
      ready    <= ready_n;
      a_mem    <= a_mem_n;
      d_mem    <= d_mem_n;
      we_mem   <= we_mem_n;
      rd_mem   <= rd_mem_n;
      if (set_valid) begin
        valid[cap_idx] <= 1'b1;
      end
    end
  end

`ifdef MAINM_CACHE_STATS_EN
  // Hit/miss counters, stepped once per LOOKUP decision; writes count as neither
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (state == S_LOOKUP) begin
      if (hit) begin
        hit_cnt <= hit_cnt + 32'd1;
      end else begin
        miss_cnt <= miss_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mainm_cache.sv
// tb/tb_mainm_cache.sv - randomized self-checking bench for mainm_cache (optional MAINM_CACHE_STATS_EN)
module tb_mainm_cache;

  localparam int IDX_W  = 8;
  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] a;
  logic [31:0]       d;
  logic              we, rd;
  logic [31:0]       spo;
  logic              ready;
  logic [ADDR_W-1:0] a_mem;
  logic [31:0]       d_mem;
  logic              we_mem, rd_mem;
  logic [31:0]       spo_mem;
  logic              ready_mem;
`ifdef MAINM_CACHE_STATS_EN
  logic [31:0]       hit_cnt, miss_cnt;
`endif

  always #5 clk = ~clk;

  mainm_cache #(
    .IDX_W  (IDX_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .d         (d),
    .we        (we),
    .rd        (rd),
    .spo       (spo),
    .ready     (ready),
    .a_mem     (a_mem),
    .d_mem     (d_mem),
    .we_mem    (we_mem),
    .rd_mem    (rd_mem),
    .spo_mem   (spo_mem),
    .ready_mem (ready_mem)
`ifdef MAINM_CACHE_STATS_EN
    ,
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Memory-side observation and the external memory contents
  int          n_rd_mem = 0;
  int          n_we_mem = 0;
  logic [31:0] last_a_mem = '0;
  logic [31:0] last_d_mem = '0;
  int          mem_lat = 3;
  logic [31:0] phys_mem [logic [31:0]];

  // Reference model: what memory should hold, and which word each line holds
  logic [31:0] exp_mem [logic [31:0]];
  logic [31:0] line_of [int];

  function automatic logic [31:0] init_val(input logic [31:0] wa);
    return (wa * 32'h9E37_79B9) ^ 32'h0BAD_F00D;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Memory responder: answers each rd_mem/we_mem after mem_lat cycles with a one-cycle ready_mem
  initial begin
    bit abort;
    ready_mem = 1'b0;
    spo_mem   = '0;
    forever begin
      @(negedge clk);
      if (!rst && (rd_mem || we_mem)) begin
        last_a_mem = a_mem;
        if (we_mem) begin
          n_we_mem++;
          last_d_mem = d_mem;
          phys_mem[a_mem] = d_mem;
        end
        if (rd_mem) n_rd_mem++;
        abort = 1'b0;
        for (int k = 1; k < mem_lat; k++) begin
          @(negedge clk);
          if (rst || !(rd_mem || we_mem)) begin
            abort = 1'b1;
            break;
          end
        end
        if (!abort) begin
          if (rd_mem) spo_mem = phys_mem.exists(a_mem) ? phys_mem[a_mem] : init_val(a_mem);
          ready_mem = 1'b1;
          @(negedge clk);
          ready_mem = 1'b0;
        end
      end
    end
  end

  // One CPU-side transaction; lat counts cycles from driving the request to seeing ready
  task automatic xact(input bit w, input bit r, input logic [31:0] addr, input logic [31:0] data,
                      output logic [31:0] rdata, output int lat);
    a = addr; d = data; we = w; rd = r;
    lat = 0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (ready) begin
        lat = c;
        break;
      end
    end
    check("ready_seen", {31'b0, ready}, 32'd1);
    rdata = spo;
    @(negedge clk);
    check("ready_pulse", {31'b0, ready}, 32'd0);
    we = 1'b0; rd = 1'b0;
  endtask

  task automatic do_op(input bit w, input bit r, input logic [31:0] addr, input logic [31:0] data,
                       input string nm);
    logic [31:0] wa;
    logic [31:0] got;
    logic [31:0] exp_val;
    int          idx;
    int          lat;
    int          rd0;
    int          we0;
    bit          exp_hit;
    wa  = {addr[31:2], 2'b00};
    idx = int'(addr[IDX_W+1:2]);
    rd0 = n_rd_mem;
    we0 = n_we_mem;
    exp_hit = !w && line_of.exists(idx) && line_of[idx] == wa;
    xact(w, r, addr, data, got, lat);
    if (w) begin
      exp_mem[wa]  = data;
      line_of[idx] = wa;
      check({nm, ".we_mem_cnt"}, 32'(n_we_mem - we0), 32'd1);
      check({nm, ".rd_mem_cnt"}, 32'(n_rd_mem - rd0), 32'd0);
      check({nm, ".a_mem"}, last_a_mem, wa);
      check({nm, ".d_mem"}, last_d_mem, data);
    end else begin
      exp_val = exp_mem.exists(wa) ? exp_mem[wa] : init_val(wa);
      check({nm, ".spo"}, got, exp_val);
      check({nm, ".rd_mem_cnt"}, 32'(n_rd_mem - rd0), exp_hit ? 32'd0 : 32'd1);
      check({nm, ".we_mem_cnt"}, 32'(n_we_mem - we0), 32'd0);
      if (exp_hit) check({nm, ".hit_lat"}, 32'(lat), 32'd2);
      else         check({nm, ".a_mem"}, last_a_mem, wa);
      line_of[idx] = wa;
    end
  endtask

  initial begin
    logic [31:0] ra;
    int          kind;
    rst = 1'b1; a = '0; d = '0; we = 1'b0; rd = 1'b0;
    repeat (3) @(negedge clk);
    check("rst.spo",    spo,               32'd0);
    check("rst.ready",  {31'b0, ready},    32'd0);
    check("rst.a_mem",  a_mem,             32'd0);
    check("rst.d_mem",  d_mem,             32'd0);
    check("rst.rd_mem", {31'b0, rd_mem},   32'd0);
    check("rst.we_mem", {31'b0, we_mem},   32'd0);
    rst = 1'b0;
    @(negedge clk);

    phys_mem[32'h2000_0040] = 32'hDEAD_BEEF;
    exp_mem[32'h2000_0040]  = 32'hDEAD_BEEF;
    mem_lat = 5;
    do_op(1'b0, 1'b1, 32'h2000_0040, 32'h0, "cold");
    do_op(1'b0, 1'b1, 32'h2000_0040, 32'h0, "warm");
    mem_lat = 3;
    do_op(1'b1, 1'b0, 32'h2000_0080, 32'h1234_5678, "wr");
    do_op(1'b0, 1'b1, 32'h2000_0080, 32'h0, "wr_rd");
`ifdef MAINM_CACHE_STATS_EN
    check("stats.hit",  hit_cnt,  32'd2);
    check("stats.miss", miss_cnt, 32'd1);
`endif

    do_op(1'b0, 1'b1, 32'h2000_0100, 32'h0, "alias_a");
    do_op(1'b0, 1'b1, 32'h2000_0500, 32'h0, "alias_b");
    do_op(1'b0, 1'b1, 32'h2000_0100, 32'h0, "alias_a2");

    do_op(1'b1, 1'b1, 32'h2000_0010, 32'hA5A5_A5A5, "both");
    do_op(1'b0, 1'b1, 32'h2000_0010, 32'h0, "both_rd");

    // Reset two cycles into a fill: the request must vanish and leave no line behind
    mem_lat = 10;
    a = 32'h2000_0200; d = '0; we = 1'b0; rd = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (rd_mem) break;
    end
    check("rstfill.start", {31'b0, rd_mem}, 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rstfill.rd_mem", {31'b0, rd_mem}, 32'd0);
    check("rstfill.ready",  {31'b0, ready},  32'd0);
    rd = 1'b0; rst = 1'b0;
    line_of.delete();
    repeat (2) @(negedge clk);
    mem_lat = 4;
    do_op(1'b0, 1'b1, 32'h2000_0200, 32'h0, "rstfill_rd");

    // Randomized mix over few lines and few tags so hits, misses and aliases all occur
    for (int i = 0; i < 60; i++) begin
      mem_lat = $urandom_range(1, 6);
      ra = 32'h2000_0000 | (32'($urandom_range(0, 7)) << 2) | (32'($urandom_range(0, 3)) << 10);
      kind = $urandom_range(0, 3);
      case (kind)
        2:       do_op(1'b1, 1'b0, ra, $urandom, "rnd_wr");
        3:       do_op(1'b1, 1'b1, ra, $urandom, "rnd_both");
        default: do_op(1'b0, 1'b1, ra, 32'h0,    "rnd_rd");
      endcase
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
